// File: rtl/axi_line_pkg.sv
// Shared types and constants for the AXI cache-line read master.
// Optional response checking is enabled with the macro AXI_LINE_RESP_CHK_EN.
package axi_line_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } axi_line_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Number of byte-offset bits inside one line.
  function automatic int line_offset_bits(input int beats, input int data_w);
    return $clog2(beats * data_w / 8);
  endfunction

  // AXI ARSIZE encoding for a full-width beat.
  function automatic int axsize_code(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_line_buf.sv
// Line storage: BEATS x DATA_W registers written by beat index, read in parallel.
// Beat 0 lives in the least-significant DATA_W bits of o_data.
module axi_line_buf #(
  parameter int BEATS  = 4,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_we,
  input  logic [$clog2(BEATS)-1:0]  i_idx,
  input  logic [DATA_W-1:0]         i_wdata,
  output logic [BEATS*DATA_W-1:0]   o_data
);

  logic [BEATS-1:0][DATA_W-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mem <= '0;
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_data = r_mem;

endmodule

// File: rtl/axi_line_read_master.sv
// Fetches one aligned cache line with a single INCR AXI read burst and presents it whole.
// Define AXI_LINE_RESP_CHK_EN to flag bad RRESP/RID/RLAST on line_err.
module axi_line_read_master
  import axi_line_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int BEATS    = 4,
  parameter int ARID_VAL = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  // request port
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  // line port
  output logic                    line_valid,
  input  logic                    line_ready,
  output logic [BEATS*DATA_W-1:0] line_data,
  output logic                    line_err,
  output logic                    busy,
  // AXI AR channel
  output logic [ID_W-1:0]         ARID,
  output logic [ADDR_W-1:0]       ARADDR,
  output logic [3:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  // AXI R channel
  input  logic [ID_W-1:0]         RID,
  input  logic [DATA_W-1:0]       RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY,
  // debug view of the FSM
  output axi_line_state_e         o_dbg_state
);

  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = line_offset_bits(BEATS, DATA_W);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [2:0] SIZE_CODE = 3'(axsize_code(DATA_W));

  // All handshakes are valid/ready: a transfer happens on a clock edge where both
  // are high; a valid, once raised, holds its payload stable until that edge.

  axi_line_state_e   r_state;
  logic              r_req_ready;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_line_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_beat_cnt;

  logic w_r_hs;
  logic w_last_slot;
  logic w_done;

  assign w_r_hs      = r_rready & RVALID;
  assign w_last_slot = (r_beat_cnt == CNT_W'(BEATS - 1));
  assign w_done      = w_r_hs & (RLAST | w_last_slot);

  // Output flags are registered alongside the state so none depends on an input.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_line_valid <= 1'b0;
      r_addr       <= '0;
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_state     <= ADDR;
            r_req_ready <= 1'b0;
            r_arvalid   <= 1'b1;
            r_addr      <= req_addr & LINE_MASK;
            r_beat_cnt  <= '0;
          end
        end
        ADDR: begin
          if (ARREADY) begin
            r_state   <= DATA;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        DATA: begin
          if (w_r_hs) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
          if (w_done) begin
            r_state      <= DONE;
            r_rready     <= 1'b0;
            r_line_valid <= 1'b1;
          end
        end
        DONE: begin
          if (line_ready) begin
            r_state      <= IDLE;
            r_line_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_arvalid    <= 1'b0;
          r_rready     <= 1'b0;
          r_line_valid <= 1'b0;
        end
      endcase
    end
  end

  axi_line_buf #(
    .BEATS  (BEATS),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (w_r_hs),
    .i_idx   (r_beat_cnt),
    .i_wdata (RDATA),
    .o_data  (line_data)
  );

`ifdef AXI_LINE_RESP_CHK_EN
  logic r_err;
  logic w_beat_err;

  // RLAST must coincide exactly with the final slot; any other pairing is a protocol error.
  assign w_beat_err = (RRESP == RESP_SLVERR) || (RRESP == RESP_DECERR) ||
                      (RID != ID_W'(ARID_VAL)) || (RLAST != w_last_slot);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (r_req_ready && req_valid) begin
      r_err <= 1'b0;
    end else if (w_r_hs && w_beat_err) begin
      r_err <= 1'b1;
    end
  end

  assign line_err = r_line_valid & r_err;
`else
  logic w_unused_resp;
  assign w_unused_resp = ^{RID, RRESP};
  assign line_err      = 1'b0;
`endif

  assign req_ready   = r_req_ready;
  assign busy        = ~r_req_ready;
  assign line_valid  = r_line_valid;
  assign RREADY      = r_rready;
  assign ARVALID     = r_arvalid;
  assign ARADDR      = r_addr;
  assign ARID        = r_arvalid ? ID_W'(ARID_VAL) : '0;
  assign ARLEN       = r_arvalid ? 4'(BEATS - 1) : 4'd0;
  assign ARSIZE      = r_arvalid ? SIZE_CODE : 3'd0;
  assign ARBURST     = r_arvalid ? AXI_BURST_INCR : 2'b00;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_line_read_master.sv
// Directed bench for axi_line_read_master (default parameters: 32-bit data, 4 beats).
// Line-error expectations follow whether AXI_LINE_RESP_CHK_EN is defined.
module tb_axi_line_read_master;
  import axi_line_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int BEATS  = 4;
  localparam int LINE_W = BEATS * DATA_W;
`ifdef AXI_LINE_RESP_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_W-1:0]    req_addr;
  logic                 line_valid;
  logic                 line_ready;
  logic [LINE_W-1:0]    line_data;
  logic                 line_err;
  logic                 busy;
  logic [ID_W-1:0]      ARID;
  logic [ADDR_W-1:0]    ARADDR;
  logic [3:0]           ARLEN;
  logic [2:0]           ARSIZE;
  logic [1:0]           ARBURST;
  logic                 ARVALID;
  logic                 ARREADY;
  logic [ID_W-1:0]      RID;
  logic [DATA_W-1:0]    RDATA;
  logic [1:0]           RRESP;
  logic                 RLAST;
  logic                 RVALID;
  logic                 RREADY;
  axi_line_state_e      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  axi_line_read_master dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .line_valid  (line_valid),
    .line_ready  (line_ready),
    .line_data   (line_data),
    .line_err    (line_err),
    .busy        (busy),
    .ARID        (ARID),
    .ARADDR      (ARADDR),
    .ARLEN       (ARLEN),
    .ARSIZE      (ARSIZE),
    .ARBURST     (ARBURST),
    .ARVALID     (ARVALID),
    .ARREADY     (ARREADY),
    .RID         (RID),
    .RDATA       (RDATA),
    .RRESP       (RRESP),
    .RLAST       (RLAST),
    .RVALID      (RVALID),
    .RREADY      (RREADY),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]           addr;
    logic [BEATS-1:0][DATA_W-1:0] beats;
    int                          last_beat;   // beat carrying RLAST (>= BEATS: never)
    int                          err_beat;    // beat carrying SLVERR (>= BEATS: never)
    logic [ID_W-1:0]             rid;
    int                          ar_wait;     // cycles ARREADY held low
    logic [ADDR_W-1:0]           exp_araddr;
    logic [LINE_W-1:0]           exp_line;
    logic                        exp_err;
    int                          exp_lat;     // cycles from acceptance cycle to line_valid
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // driver: one full request / AR / R sequence, stops when line_valid rises
  task automatic do_line(input string tag, input vec_t v);
    int   beat;
    int   cyc;
    logic hs;
    check({tag, "_req_ready_idle"}, LINE_W'(req_ready), LINE_W'(1));
    req_valid = 1'b1;
    req_addr  = v.addr;
    step();
    req_valid = 1'b0;
    req_addr  = '0;
    cyc = 1;
    check({tag, "_arvalid"}, LINE_W'(ARVALID), LINE_W'(1));
    check({tag, "_araddr"},  LINE_W'(ARADDR),  LINE_W'(v.exp_araddr));
    check({tag, "_arlen"},   LINE_W'(ARLEN),   LINE_W'(3));
    check({tag, "_arsize"},  LINE_W'(ARSIZE),  LINE_W'(2));
    check({tag, "_arburst"}, LINE_W'(ARBURST), LINE_W'(1));
    check({tag, "_arid"},    LINE_W'(ARID),    LINE_W'(0));
    beat = 0;
    while (!line_valid && cyc < 60) begin
      ARREADY = (cyc > v.ar_wait);
      if (beat < BEATS) begin
        RVALID = 1'b1;
        RDATA  = v.beats[beat];
        RLAST  = (beat == v.last_beat);
        RRESP  = (beat == v.err_beat) ? RESP_SLVERR : RESP_OKAY;
        RID    = v.rid;
      end else begin
        RVALID = 1'b0;
      end
      if (cyc <= v.ar_wait) begin
        check({tag, "_ar_hold_valid"}, LINE_W'(ARVALID), LINE_W'(1));
        check({tag, "_ar_hold_addr"},  LINE_W'(ARADDR),  LINE_W'(v.exp_araddr));
        check({tag, "_ar_hold_rready"}, LINE_W'(RREADY), LINE_W'(0));
      end
      hs = RREADY & RVALID;
      step();
      if (hs) beat++;
      cyc++;
    end
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    RRESP   = RESP_OKAY;
    RID     = '0;
    ARREADY = 1'b0;
    check({tag, "_line_valid"}, LINE_W'(line_valid), LINE_W'(1));
    check({tag, "_line_data"},  line_data,           v.exp_line);
    check({tag, "_line_err"},   LINE_W'(line_err),   LINE_W'(v.exp_err));
    check({tag, "_latency"},    LINE_W'(cyc),        LINE_W'(v.exp_lat));
    check({tag, "_rready_done"}, LINE_W'(RREADY),    LINE_W'(0));
  endtask

  task automatic release_line(input string tag);
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    check({tag, "_rel_req_ready"},  LINE_W'(req_ready),  LINE_W'(1));
    check({tag, "_rel_busy"},       LINE_W'(busy),       LINE_W'(0));
    check({tag, "_rel_line_valid"}, LINE_W'(line_valid), LINE_W'(0));
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_addr = '0; line_ready = 1'b0;
    ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RVALID = 1'b0;

    vecs[0] = '{32'h0000_1234, {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}, 3, 9, 4'h0, 0,
                32'h0000_1230, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 1'b0, 6};
    vecs[1] = '{32'h8000_003F, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 3, 9, 4'h0, 5,
                32'h8000_0030, 128'h44444444_33333333_22222222_11111111, 1'b0, 11};
    vecs[2] = '{32'h0000_0100, {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000}, 3, 2, 4'h0, 0,
                32'h0000_0100, 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000, ERR_EN, 6};
    vecs[3] = '{32'h0FFF_FFFF, {32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000}, 3, 9, 4'h0, 0,
                32'h0FFF_FFF0, 128'h5A5A0003_5A5A0002_5A5A0001_5A5A0000, 1'b0, 6};
    vecs[4] = '{32'h0000_0048, {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0}, 1, 9, 4'h0, 0,
                32'h0000_0040, 128'h5A5A0003_5A5A0002_C1C1C1C1_C0C0C0C0, ERR_EN, 4};
    vecs[5] = '{32'h0000_2008, {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A}, 9, 9, 4'h0, 0,
                32'h0000_2000, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, ERR_EN, 6};
    vecs[6] = '{32'h0000_3010, {32'h77770003, 32'h77770002, 32'h77770001, 32'h77770000}, 3, 9, 4'h3, 0,
                32'h0000_3010, 128'h77770003_77770002_77770001_77770000, ERR_EN, 6};

    // reset state
    step();
    step();
    check("rst_req_ready",  LINE_W'(req_ready),  LINE_W'(1));
    check("rst_busy",       LINE_W'(busy),       LINE_W'(0));
    check("rst_arvalid",    LINE_W'(ARVALID),    LINE_W'(0));
    check("rst_araddr",     LINE_W'(ARADDR),     LINE_W'(0));
    check("rst_arlen",      LINE_W'(ARLEN),      LINE_W'(0));
    check("rst_rready",     LINE_W'(RREADY),     LINE_W'(0));
    check("rst_line_valid", LINE_W'(line_valid), LINE_W'(0));
    check("rst_line_data",  line_data,           LINE_W'(0));
    check("rst_line_err",   LINE_W'(line_err),   LINE_W'(0));
    check("rst_state",      LINE_W'(dbg_state),  LINE_W'(IDLE));
    rstn = 1'b1;
    step();
    check("post_rst_req_ready", LINE_W'(req_ready), LINE_W'(1));

    // table-driven lines
    for (int i = 0; i < 7; i++) begin
      do_line($sformatf("v%0d", i), vecs[i]);
      release_line($sformatf("v%0d", i));
    end

    // line backpressure with a pending request
    do_line("bp", vecs[0]);
    req_valid = 1'b1;
    req_addr  = 32'h0000_5004;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_req_ready_low", LINE_W'(req_ready),  LINE_W'(0));
      check("bp_line_valid",    LINE_W'(line_valid), LINE_W'(1));
      check("bp_line_stable",   line_data,           vecs[0].exp_line);
    end
    line_ready = 1'b1;
    step();
    line_ready = 1'b0;
    check("bp_idle_req_ready", LINE_W'(req_ready), LINE_W'(1));
    check("bp_idle_arvalid",   LINE_W'(ARVALID),   LINE_W'(0));
    step();
    req_valid = 1'b0;
    check("bp_accept_arvalid", LINE_W'(ARVALID), LINE_W'(1));
    check("bp_accept_araddr",  LINE_W'(ARADDR),  LINE_W'(32'h0000_5000));

    // reset mid-burst: beats 0 and 1 accepted, then reset
    ARREADY = 1'b1;
    step();
    ARREADY = 1'b0;
    check("mid_state_data", LINE_W'(dbg_state), LINE_W'(DATA));
    RVALID = 1'b1; RDATA = 32'hBEEF0000;
    step();
    RDATA = 32'hBEEF0001;
    step();
    RDATA = 32'hBEEF0002;
    rstn  = 1'b0;
    step();
    rstn = 1'b1;
    check("mid_busy",       LINE_W'(busy),       LINE_W'(0));
    check("mid_line_valid", LINE_W'(line_valid), LINE_W'(0));
    check("mid_req_ready",  LINE_W'(req_ready),  LINE_W'(1));
    check("mid_line_data",  line_data,           LINE_W'(0));
    for (int k = 0; k < 4; k++) begin
      step();
      check("mid_no_arvalid", LINE_W'(ARVALID), LINE_W'(0));
      check("mid_no_rready",  LINE_W'(RREADY),  LINE_W'(0));
    end
    RVALID = 1'b0;
    check("mid_buf_untouched", line_data, LINE_W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_line_read_master.md
AXI_LINE_READ_MASTER -- requirements
Module: axi_line_read_master

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  ADDR_W, 32, address width;
  DATA_W, 32, AXI data width (32 or 64);
  ID_W, 4, AXI ID width;
  BEATS, 4, beats per line (power of 2, 2..16);
  ARID_VAL, 0, constant ARID.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk, in, 1, clock;
  rstn, in, 1, reset, synchronous, active-low.
REQ-003 Request port:
  req_valid, in, 1;
  req_ready, out, 1;
  req_addr, in, ADDR_W, byte address anywhere in the line.
REQ-004 Line port:
  line_valid, out, 1;
  line_ready, in, 1;
  line_data, out, BEATS*DATA_W, beat 0 in the LSBs;
  line_err, out, 1, error flag.
REQ-005 busy, out, 1, high whenever state is not IDLE.
REQ-006 AXI AR channel:
  ARID, out, ID_W;
  ARADDR, out, ADDR_W;
  ARLEN, out, 4;
  ARSIZE, out, 3;
  ARBURST, out, 2;
  ARVALID, out, 1;
  ARREADY, in, 1.
REQ-007 AXI R channel:
  RID, in, ID_W;
  RDATA, in, DATA_W;
  RRESP, in, 2;
  RLAST, in, 1;
  RVALID, in, 1;
  RREADY, out, 1.

Function
REQ-008 The FSM SHALL have states IDLE, ADDR, DATA and DONE.
REQ-009 req_ready SHALL equal (state==IDLE), with no combinational path from req_valid.
REQ-010 IDLE SHALL go to ADDR on the req_valid&req_ready handshake and latch req_addr with its low log2(BEATS*DATA_W/8) bits cleared.
REQ-011 ARVALID SHALL be high only in ADDR, first asserted the cycle after request acceptance.
REQ-012 ARADDR, ARLEN, ARSIZE and ARBURST SHALL stay stable while ARVALID is high.
REQ-013 ADDR SHALL go to DATA on ARVALID&ARREADY.
REQ-014 ARLEN SHALL be BEATS-1, ARSIZE SHALL be log2(DATA_W/8), ARBURST SHALL be INCR (2'b01), and ARID SHALL be ARID_VAL.
REQ-015 RREADY SHALL be high only in DATA; R beats in any other state are not accepted.
REQ-016 Each R handshake SHALL write RDATA into slot beat_cnt of the line buffer and increment beat_cnt, which is log2(BEATS) bits wide.
REQ-017 DATA SHALL go to DONE on the first R handshake with RLAST=1 or beat_cnt==BEATS-1, whichever comes first; unwritten slots keep their prior contents.
REQ-018 line_valid SHALL equal (state==DONE), and line_data SHALL stay stable while line_valid is high.
REQ-019 DONE SHALL go to IDLE on line_ready; req_ready rises the following cycle, giving no back-to-back acceptance.
REQ-020 Minimum latency from request acceptance to line_valid SHALL be BEATS+2 cycles, with ARREADY and RVALID high on first opportunity.
REQ-021 beat_cnt SHALL clear on entry to ADDR.

Reset
REQ-022 When rstn is low at a clk edge, the state SHALL become IDLE and beat_cnt, the line buffer, the latched address and line_err SHALL clear.
REQ-023 During reset all outputs SHALL be 0 except req_ready, which SHALL be 1 the first cycle after reset.
REQ-024 A reset mid-burst SHALL abandon the transaction with no reissue, and remaining R beats are not accepted.

Configuration
REQ-025 The feature SHALL be controlled by macro AXI_LINE_RESP_CHK_EN.
REQ-026 With AXI_LINE_RESP_CHK_EN defined, a sticky error SHALL be set by any of:
  RRESP of SLVERR or DECERR on any beat;
  RID not equal to ARID_VAL;
  RLAST=1 before the last beat;
  RLAST=0 on the last beat.
REQ-027 The sticky error SHALL drive line_err in DONE and SHALL clear on entry to ADDR.
REQ-028 With AXI_LINE_RESP_CHK_EN undefined, line_err SHALL be tied 0, RID and RRESP SHALL be ignored, and the ports SHALL remain present.

Structure
REQ-029 Package axi_line_pkg SHALL hold:
  the state enum;
  AXI_BURST_INCR;
  RESP_OKAY, RESP_SLVERR and RESP_DECERR;
  function clog2-based size helpers.
REQ-030 One sub-module, axi_line_buf (BEATS x DATA_W write-by-index register array with parallel read), SHALL hold the line storage; the FSM stays in the top module.

Verification
REQ-031 Basic line fill: req_addr=0x0000_1234, BEATS=4, ARREADY=1, RDATA=A0..A3 with RLAST on beat 3 -> ARADDR=0x1230, ARLEN=3, ARSIZE=2, and line_data={A3,A2,A1,A0} with line_valid exactly 6 cycles after acceptance.
REQ-032 AR backpressure: ARREADY held low for 5 cycles -> ARVALID and ARADDR held stable for 5 cycles, and RREADY stays 0.
REQ-033 Line backpressure: line_ready low for 3 cycles in DONE with req_valid high -> req_ready stays 0, line_data is unchanged, and the request is accepted 1 cycle after line_ready.
REQ-034 Reset mid-burst: rstn pulled low after beat 1 -> the next cycle is IDLE with busy=0 and line_valid=0, and no second AR is issued.
REQ-035 Response checking (macro defined): RRESP=SLVERR on beat 2 -> line_err=1 with line_valid, and the next clean line gives line_err=0.
REQ-036 Early RLAST (macro defined): RLAST on beat 1 -> DONE after beat 1 with line_err=1; with the macro undefined, line_err=0.
